// File: rtl/tpu_layer_sequencer.sv
// rtl/tpu_layer_sequencer.sv - layer engine sequencer with argmax class readout
//
// Purpose:
//   Steps NUM_LAYERS fully-connected layer engines in order. Each engine is
//   enabled, given a one-cycle active-low reset pulse, and then awaited until
//   it reports done. layer_sel drives the shared ROM/MultAdder mux select.
//   After the last layer, the final scores are snapshotted and a sequential
//   argmax (one signed compare per cycle) produces the winning class.
//
// Ports:
//   clk         rising-edge clock
//   iRst        synchronous active-high reset
//   ena         global enable; low freezes every register
//   start       one-cycle inference request, accepted only in IDLE or DONE
//   layer_done  per-engine done flags; only bit layer_sel is looked at
//   scores      packed signed final-layer scores, class k at [k*BIT +: BIT]
//   layer_ena   one-hot enable of the active engine
//   layer_rstn  active-low reset pulse to the engines
//   layer_sel   index of the active engine
//   busy        high from start acceptance until done rises
//   num_out     winning class index
//   done        result valid, held until the next accepted start or reset
//   error       watchdog fired
//
// Optional feature macro: TPU_SEQ_WATCHDOG_EN
//   Defined: per-layer watchdog of TIMEOUT_CYC enabled LRUN cycles; on expiry
//   the run ends in DONE with error=1 and num_out all ones.
//   Undefined: no watchdog, error is tied low and LRUN waits indefinitely.

module tpu_layer_sequencer #(
  parameter int NUM_LAYERS  = 2,
  parameter int BIT         = 8,
  parameter int NUM_CLASSES = 10,
  parameter int SEL_W       = 3,
  parameter int OUT_W       = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                       clk,
  input  logic                       iRst,
  input  logic                       ena,
  input  logic                       start,
  input  logic [NUM_LAYERS-1:0]      layer_done,
  input  logic [NUM_CLASSES*BIT-1:0] scores,
  output logic [NUM_LAYERS-1:0]      layer_ena,
  output logic [NUM_LAYERS-1:0]      layer_rstn,
  output logic [SEL_W-1:0]           layer_sel,
  output logic                       busy,
  output logic [OUT_W-1:0]           num_out,
  output logic                       done,
  output logic                       error
);

  localparam int IDX_W = $clog2(NUM_CLASSES);

  if (NUM_LAYERS < 1 || NUM_LAYERS > 8 || (2 ** SEL_W) < NUM_LAYERS ||
      NUM_CLASSES < 2 || NUM_CLASSES > 16 || (2 ** OUT_W) < NUM_CLASSES ||
      TIMEOUT_CYC < 1) begin : g_bad_params
    $error("tpu_layer_sequencer: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LRST,
    S_LRUN,
    S_ARGMAX,
    S_DONE
  } state_t;

  state_t                  state_q;
  logic [NUM_LAYERS-1:0]   layer_ena_q;
  logic [NUM_LAYERS-1:0]   layer_rstn_q;
  logic [SEL_W-1:0]        layer_sel_q;
  logic                    busy_q;
  logic [OUT_W-1:0]        num_out_q;
  logic                    done_q;

  logic signed [BIT-1:0]   snap_q [NUM_CLASSES];
  logic [IDX_W-1:0]        idx_q;
  logic signed [BIT-1:0]   best_val_q;
  logic [IDX_W-1:0]        best_idx_q;

  logic signed [BIT-1:0]   cur_score;
  logic                    take_cur;
  logic signed [BIT-1:0]   best_val_d;
  logic [IDX_W-1:0]        best_idx_d;
  logic                    sel_done;
  logic                    last_layer;
  logic                    last_class;

`ifdef TPU_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0]         wd_q;
  logic                    error_q;
`endif

  function automatic logic [NUM_LAYERS-1:0] onehot(input logic [SEL_W-1:0] s);
    logic [NUM_LAYERS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      oh[i] = (s == SEL_W'(i));
    end
    return oh;
  endfunction

  // Only the active engine's done bit matters; others are masked off.
  assign sel_done   = |(layer_done & onehot(layer_sel_q));
  assign last_layer = (layer_sel_q == SEL_W'(NUM_LAYERS - 1));
  assign last_class = (idx_q == IDX_W'(NUM_CLASSES - 1));

  // Class 0 seeds the running maximum; later classes replace it only when
  // strictly greater, so ties keep the lowest index.
  always_comb begin
    cur_score  = snap_q[idx_q];
    take_cur   = (idx_q == '0) || (cur_score > best_val_q);
    best_val_d = take_cur ? cur_score : best_val_q;
    best_idx_d = take_cur ? idx_q : best_idx_q;
  end

  always_ff @(posedge clk) begin
    if (iRst) begin
      state_q      <= S_IDLE;
      layer_ena_q  <= '0;
      layer_rstn_q <= '1;
      layer_sel_q  <= '0;
      busy_q       <= 1'b0;
      num_out_q    <= '0;
      done_q       <= 1'b0;
      idx_q        <= '0;
      best_val_q   <= '0;
      best_idx_q   <= '0;
      for (int k = 0; k < NUM_CLASSES; k++) begin
        snap_q[k] <= '0;
      end
`ifdef TPU_SEQ_WATCHDOG_EN
      wd_q         <= '0;
      error_q      <= 1'b0;
`endif
    end else if (ena) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q     <= S_LRST;
            layer_sel_q <= '0;
            layer_ena_q <= onehot('0);
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
`ifdef TPU_SEQ_WATCHDOG_EN
            error_q     <= 1'b0;
`endif
          end
        end

        S_LRST: begin
          layer_ena_q  <= onehot(layer_sel_q);
          layer_rstn_q <= ~onehot(layer_sel_q);
`ifdef TPU_SEQ_WATCHDOG_EN
          wd_q         <= '0;
`endif
          state_q      <= S_LRUN;
        end

        S_LRUN: begin
          layer_rstn_q <= '1;
          if (sel_done) begin
            if (last_layer) begin
              layer_ena_q <= '0;
              for (int k = 0; k < NUM_CLASSES; k++) begin
                snap_q[k] <= scores[k*BIT +: BIT];
              end
              idx_q       <= '0;
              state_q     <= S_ARGMAX;
            end else begin
              // Moving the one-hot enable here disables the finished engine
              // in the same edge that selects the next one.
              layer_sel_q <= layer_sel_q + 1'b1;
              layer_ena_q <= onehot(layer_sel_q + 1'b1);
              state_q     <= S_LRST;
            end
          end
`ifdef TPU_SEQ_WATCHDOG_EN
          else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
            error_q     <= 1'b1;
            layer_ena_q <= '0;
            num_out_q   <= '1;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_DONE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
`endif
        end

        S_ARGMAX: begin
          if (last_class) begin
            num_out_q <= OUT_W'(best_idx_d);
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_DONE;
          end else begin
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            idx_q      <= idx_q + 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign layer_ena  = layer_ena_q;
  assign layer_rstn = layer_rstn_q;
  assign layer_sel  = layer_sel_q;
  assign busy       = busy_q;
  assign num_out    = num_out_q;
  assign done       = done_q;

`ifdef TPU_SEQ_WATCHDOG_EN
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_tpu_layer_sequencer.sv
// tb/tb_tpu_layer_sequencer.sv - self-checking bench for tpu_layer_sequencer

module tb_tpu_layer_sequencer;

  localparam int NL    = 3;
  localparam int BIT   = 8;
  localparam int NC    = 10;
  localparam int SEL_W = 3;
  localparam int OUT_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                iRst;
  logic                ena;
  logic                start;
  logic [NL-1:0]       layer_done;
  logic [NC*BIT-1:0]   scores;
  logic [NL-1:0]       layer_ena;
  logic [NL-1:0]       layer_rstn;
  logic [SEL_W-1:0]    layer_sel;
  logic                busy;
  logic [OUT_W-1:0]    num_out;
  logic                done;
  logic                error;

  tpu_layer_sequencer #(
    .NUM_LAYERS (NL),
    .BIT        (BIT),
    .NUM_CLASSES(NC),
    .SEL_W      (SEL_W),
    .OUT_W      (OUT_W)
  ) dut (
    .clk       (clk),
    .iRst      (iRst),
    .ena       (ena),
    .start     (start),
    .layer_done(layer_done),
    .scores    (scores),
    .layer_ena (layer_ena),
    .layer_rstn(layer_rstn),
    .layer_sel (layer_sel),
    .busy      (busy),
    .num_out   (num_out),
    .done      (done),
    .error     (error)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Engine models: engine i raises done d_cur[i] enabled cycles after its
  // reset pulse ends, and stays done while enabled. noise injects spurious
  // done pulses on engines that are not enabled.
  int            d_cur [NL];
  int            eng_cnt [NL];
  logic [NL-1:0] noise;

  initial for (int i = 0; i < NL; i++) eng_cnt[i] = 0;

  always @(posedge clk) begin
    if (ena) begin
      for (int i = 0; i < NL; i++) begin
        if (!layer_rstn[i]) eng_cnt[i] <= 0;
        else if (layer_ena[i] && eng_cnt[i] < 1000) eng_cnt[i] <= eng_cnt[i] + 1;
      end
    end
  end

  always_comb begin
    layer_done = '0;
    for (int i = 0; i < NL; i++) begin
      layer_done[i] = (layer_ena[i] && layer_rstn[i] && (eng_cnt[i] >= d_cur[i] - 1)) ||
                      (noise[i] && !layer_ena[i]);
    end
  end

  // Behavioural reference: a run is a count k of enabled edges since start
  // acceptance. Layer i occupies k in [B[i], B[i+1]) with B[i+1]=B[i]+2+d_i,
  // argmax occupies [L, L+NC), and the result is valid from k = L+NC.
  bit              m_valid = 1'b0;
  bit              m_act;
  int              m_k;
  int              m_L;
  int              m_B [NL+1];
  logic [OUT_W-1:0] m_num;
  logic [OUT_W-1:0] m_win;

  function automatic int argmax_ref(input logic [NC*BIT-1:0] s);
    int best;
    best = 0;
    for (int k = 1; k < NC; k++) begin
      if ($signed(s[k*BIT +: BIT]) > $signed(s[best*BIT +: BIT])) best = k;
    end
    return best;
  endfunction

  always @(posedge clk) begin
    if (iRst) begin
      m_valid = 1'b1;
      m_act   = 1'b0;
      m_num   = '0;
    end else if (ena && m_valid) begin
      if (m_act && m_k < m_L + NC) begin
        m_k++;
        if (m_k == m_L) m_win = OUT_W'(argmax_ref(scores));
        if (m_k == m_L + NC) m_num = m_win;
      end else if (start) begin
        m_act  = 1'b1;
        m_k    = 0;
        m_B[0] = 0;
        for (int i = 0; i < NL; i++) m_B[i+1] = m_B[i] + 2 + d_cur[i];
        m_L = m_B[NL];
      end
    end
  end

  always @(negedge clk) begin
    logic [NL-1:0] e_ena;
    logic [NL-1:0] e_rstn;
    int            e_sel;
    bit            e_busy;
    bit            e_done;
    if (m_valid) begin
      e_ena  = '0;
      e_rstn = '1;
      e_sel  = 0;
      e_busy = 1'b0;
      e_done = 1'b0;
      if (m_act) begin
        if (m_k < m_L) begin
          e_busy = 1'b1;
          for (int i = 0; i < NL; i++) begin
            if (m_k >= m_B[i] && m_k < m_B[i+1]) begin
              e_sel = i;
              e_ena = NL'(1) << i;
              if (m_k == m_B[i] + 1) e_rstn = ~(NL'(1) << i);
            end
          end
        end else if (m_k < m_L + NC) begin
          e_sel  = NL - 1;
          e_busy = 1'b1;
        end else begin
          e_sel  = NL - 1;
          e_done = 1'b1;
        end
      end
      chk("layer_ena", layer_ena, e_ena);
      chk("layer_rstn", layer_rstn, e_rstn);
      chk("layer_sel", layer_sel, e_sel);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("num_out", num_out, m_num);
      chk("error", error, 0);
    end
  end

  logic [NL-1:0]    ena_seq [$];
  logic [SEL_W-1:0] sel_seq [$];
  int               rlow [NL];

  task automatic load_scores(input int s [NC]);
    for (int k = 0; k < NC; k++) scores[k*BIT +: BIT] = BIT'(s[k]);
  endtask

  task automatic rand_scores();
    logic [BIT-1:0] v;
    for (int k = 0; k < NC; k++) begin
      v = ($urandom_range(0, 1) == 1) ? BIT'($urandom) : BIT'($urandom_range(0, 3));
      scores[k*BIT +: BIT] = v;
    end
  endtask

  // Starts a run from IDLE/DONE and counts edges after the accepting edge
  // until done is seen. Optionally freezes ena for 4 cycles in layer 0 LRUN
  // and 4 cycles in ARGMAX, and optionally injects a stray done on engine 2
  // during layer 0 plus a stray start during ARGMAX.
  task automatic run_directed(input bit freeze, input bit pulse, output int edges);
    logic [NL-1:0] last_ena;
    ena_seq.delete();
    sel_seq.delete();
    for (int i = 0; i < NL; i++) rlow[i] = 0;
    last_ena = layer_ena;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    forever begin
      if (layer_ena != last_ena) begin
        ena_seq.push_back(layer_ena);
        last_ena = layer_ena;
      end
      if (busy && (sel_seq.size() == 0 || sel_seq[$] != layer_sel)) sel_seq.push_back(layer_sel);
      for (int i = 0; i < NL; i++) if (!layer_rstn[i]) rlow[i]++;
      if (done || edges >= 300) break;
      ena   = !(freeze && ((edges >= 3 && edges < 7) || (edges >= 28 && edges < 32)));
      noise = (pulse && edges == 2) ? NL'(4) : NL'(0);
      start = pulse && (edges == 25);
      @(negedge clk);
      edges++;
    end
    ena   = 1'b1;
    noise = '0;
    start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_layer_ena"}, layer_ena, 0);
    chk({tag, "_layer_rstn"}, layer_rstn, 3'b111);
    chk({tag, "_layer_sel"}, layer_sel, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_num_out"}, num_out, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int               sc [NC];
    int               edges;
    int               cyc;
    logic [NL-1:0]    exp_ena [4];
    iRst  = 1'b1;
    ena   = 1'b1;
    start = 1'b0;
    noise = '0;
    scores = '0;
    for (int i = 0; i < NL; i++) d_cur[i] = 1;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    iRst = 1'b0;
    @(negedge clk);

    d_cur[0] = 5; d_cur[1] = 7; d_cur[2] = 3;

    // Basic run: 2+5+2+7+2+3+10 = 31 edges, winner class 2.
    sc = '{3, -1, 9, 2, 0, 0, 0, 0, 0, 1};
    load_scores(sc);
    run_directed(1'b0, 1'b1, edges);
    chk("basic_latency", edges, 31);
    chk("basic_num_out", num_out, 2);
    chk("basic_busy_low", busy, 0);
    exp_ena[0] = 3'b001; exp_ena[1] = 3'b010; exp_ena[2] = 3'b100; exp_ena[3] = 3'b000;
    chk("ena_seq_len", ena_seq.size(), 4);
    for (int i = 0; i < 4; i++) if (i < ena_seq.size()) chk("ena_seq", ena_seq[i], exp_ena[i]);
    chk("sel_seq_len", sel_seq.size(), 3);
    for (int i = 0; i < 3; i++) if (i < sel_seq.size()) chk("sel_seq", sel_seq[i], i);
    for (int i = 0; i < NL; i++) chk("rstn_pulse_once", rlow[i], 1);

    // Tie between classes 4 and 7 with two 4-cycle freezes: 31 + 8 edges.
    sc = '{-5, -5, -5, -5, 6, -5, -5, 6, -5, -5};
    load_scores(sc);
    run_directed(1'b1, 1'b0, edges);
    chk("freeze_latency", edges, 39);
    chk("tie_num_out", num_out, 4);

    // All classes equal: lowest index wins.
    sc = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7};
    load_scores(sc);
    run_directed(1'b0, 1'b0, edges);
    chk("equal_latency", edges, 31);
    chk("equal_num_out", num_out, 0);

    // Reset in the middle of layer 1's run phase, then a clean rerun.
    sc = '{3, -1, 9, 2, 0, 0, 0, 0, 0, 1};
    load_scores(sc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(busy && layer_sel == 1 && layer_ena == 3'b010 && layer_rstn == 3'b111 && cyc > 9) &&
           cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_layer1_run", cyc < 100, 1);
    repeat (2) @(negedge clk);
    iRst = 1'b1;
    @(negedge clk);
    iRst = 1'b0;
    chk_reset_vals("midrun_reset");
    run_directed(1'b0, 1'b0, edges);
    chk("after_reset_latency", edges, 31);
    chk("after_reset_num_out", num_out, 2);

    // Randomized runs against the reference model.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < NL; i++) d_cur[i] = $urandom_range(1, 6);
      rand_scores();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (m_act && m_k < m_L + NC && cyc < 600) begin
        rand_scores();
        ena   = ($urandom_range(0, 7) != 0);
        noise = NL'($urandom);
        start = ($urandom_range(0, 15) == 0);
        iRst  = (r % 8 == 5) && (cyc == 10 + r);
        @(negedge clk);
        cyc++;
      end
      chk("rand_run_bounded", cyc < 600, 1);
      start = 1'b0;
      iRst  = 1'b0;
      ena   = 1'b1;
      noise = '0;
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tpu_layer_sequencer.md
Name: tpu_layer_sequencer

Overview:
Parametrised successor of the two-stage TPU controller. It sequences NUM_LAYERS fully-connected layer engines in order: enable, reset pulse, then wait for done. It drives the select index for the shared ROM/MultAdder muxes. When the last layer finishes, it runs a sequential argmax over the final-layer scores and reports the winning class with a start/done handshake.

Parameters:
NUM_LAYERS, 2, number of layer engines sequenced (1..8)
BIT, 8, signed width of one class score
NUM_CLASSES, 10, number of scores from the last layer (2..16)
SEL_W, 3, width of layer_sel (must satisfy 2^SEL_W >= NUM_LAYERS)
OUT_W, 4, width of num_out (must satisfy 2^OUT_W >= NUM_CLASSES)
TIMEOUT_CYC, 65535, watchdog limit per layer (used only with the optional feature)

Ports:
clk  input  1  rising-edge clock
iRst  input  1  synchronous active-high reset
ena  input  1  global enable; low freezes all state, counters and outputs
start  input  1  1-cycle request to begin inference; ignored unless state is IDLE or DONE
layer_done  input  NUM_LAYERS  per-engine done flag; only bit layer_sel is sampled
scores  input  NUM_CLASSES*BIT  packed signed final-layer scores; class k is at [k*BIT +: BIT]
layer_ena  output  NUM_LAYERS  one-hot enable to the active engine
layer_rstn  output  NUM_LAYERS  active-low reset pulse to the engines
layer_sel  output  SEL_W  index of the active engine, used as the shared-resource mux select
busy  output  1  high from start acceptance until done rises
num_out  output  OUT_W  winning class index
done  output  1  result valid; held high until the next accepted start or reset
error  output  1  watchdog fired (optional feature only; otherwise tied 0)

Behaviour:
- Reset (iRst=1 at a clk edge), from any state including mid-run:
  - state=IDLE
  - layer_ena=0, layer_rstn=all 1, layer_sel=0
  - busy=0, num_out=0, done=0, error=0
  - score snapshot and argmax counters cleared
- ena=0: no state, counter or output changes. Outputs hold their last values and are not tristated. Reset still has priority over ena.
- States: IDLE, LRST, LRUN, ARGMAX, DONE.
- IDLE/DONE + start:
  - next state LRST with layer_sel=0
  - busy=1, done=0, error=0
  - num_out is held until it is overwritten.
- LRST (1 cycle):
  - layer_ena = one-hot(layer_sel)
  - layer_rstn[layer_sel]=0, all other bits 1
  - next state LRUN
- LRUN:
  - layer_rstn = all 1; layer_ena is held.
  - If layer_done[layer_sel]=1 and layer_sel<NUM_LAYERS-1: layer_sel increments, next state LRST. The new one-hot enable is applied in the same edge, so the previous engine is disabled.
  - If layer_done[layer_sel]=1 and this is the last layer: layer_ena=0, scores are latched into the snapshot, next state ARGMAX.
  - layer_done bits of inactive engines are ignored.
- ARGMAX:
  - Runs exactly NUM_CLASSES cycles over the snapshot, one compare per cycle, index 0 first.
  - Compare is signed and strictly greater, so a tie resolves to the lowest index.
  - On the final compare cycle: num_out=winner, done=1, busy=0, next state DONE.
- DONE: start re-runs from layer 0. start is ignored in LRST, LRUN and ARGMAX.
- Latency: start accepted at edge t, with each engine asserting done d_i cycles after its layer_rstn deasserts. done rises at edge t + sum(2 + d_i) + NUM_CLASSES.
- NUM_LAYERS=1: the sequence goes LRST, LRUN, ARGMAX, with no increment step.

Optional Feature:
Macro TPU_SEQ_WATCHDOG_EN.
- Defined:
  - A counter clears on entry to LRST and increments each enabled LRUN cycle.
  - When it reaches TIMEOUT_CYC without layer_done: error=1, layer_ena=0, num_out = all ones, done=1, busy=0, next state DONE.
  - error clears on the next accepted start or reset.
- Not defined: no counter exists, error is constant 0, and LRUN waits indefinitely.

Test Plan:
- NUM_LAYERS=2; engines assert done 5 and 7 cycles after rstn release; scores 3,-1,9,2,0,0,0,0,0,1 -> num_out=2, done rises exactly 2+5+2+7+10 = 26 edges after start, one-hot layer_ena sequence 01 -> 10 -> 00.
- Scores all -5 except classes 4 and 7 = 6 -> num_out=4 (tie to lowest index); all equal -> num_out=0.
- NUM_LAYERS=3; layer_done[2] pulsed during layer 0 -> ignored; layer_sel steps 0,1,2; layer_rstn pulses one cycle low exactly once per engine.
- ena low for 4 cycles mid-LRUN, and again mid-ARGMAX -> state and outputs frozen; done is delayed by exactly 4 cycles per freeze; result unchanged.
- iRst asserted during LRUN of layer 1 -> next edge all outputs at reset values; a subsequent start runs cleanly from layer 0; start pulsed during ARGMAX -> ignored.
- With TPU_SEQ_WATCHDOG_EN and TIMEOUT_CYC=20, engine never done -> error=1, done=1, num_out=4'b1111, layer_ena=0 at edge 20 of LRUN; next start clears error.
